// File: rtl/vtiming_pkg.sv
// rtl/vtiming_pkg.sv - FSM states and PROM bit map for vtiming_reader
package vtiming_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    LATCH = 2'd2
  } vt_state_t;

  localparam int VT_IRQ    = 0;
  localparam int VT_VSYNC  = 1;
  localparam int VT_VBLANK = 2;
  localparam int VT_VRST   = 3;
endpackage

// File: rtl/vtiming_decode.sv
// rtl/vtiming_decode.sv - latches the PROM nibble into vblank/vsync/vrst and owns the sticky irq
module vtiming_decode
  import vtiming_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_latch_en,
  input  logic [3:0] i_prom_d,
  input  logic       i_irq_ack,
  output logic       o_vblank,
  output logic       o_vsync,
  output logic       o_vrst,
  output logic       o_irq
);
  logic r_vblank;
  logic r_vsync;
  logic r_vrst;
  logic r_d0_q;
  logic r_irq;
  logic w_irq_set;

  // Only a 0->1 transition of d[0] between latched lines raises an interrupt
  assign w_irq_set = i_latch_en & i_prom_d[VT_IRQ] & ~r_d0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank <= 1'b1;
      r_vsync  <= 1'b0;
      r_vrst   <= 1'b0;
      r_d0_q   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (i_latch_en) begin
        r_vblank <= i_prom_d[VT_VBLANK];
        r_vsync  <= i_prom_d[VT_VSYNC];
        r_vrst   <= i_prom_d[VT_VRST];
        r_d0_q   <= i_prom_d[VT_IRQ];
      end
      if (w_irq_set)
        r_irq <= 1'b1;
      else if (i_irq_ack)
        r_irq <= 1'b0;
    end
  end

  assign o_vblank = r_vblank;
  assign o_vsync  = r_vsync;
  assign o_vrst   = r_vrst;
  assign o_irq    = r_irq;
endmodule

// File: rtl/vtiming_reader.sv
// rtl/vtiming_reader.sv - per-scanline PROM read sequencer; VTIMING_ASYNC_PROM_EN selects a combinational PROM (no WAIT)
module vtiming_reader
  import vtiming_pkg::*;
#(
  parameter logic [7:0] RESET_LINE = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_stb,
  output logic [7:0] prom_a,
  input  logic [3:0] prom_d,
  output logic [7:0] vcount,
  output logic       vblank,
  output logic       vsync,
  output logic       irq,
  input  logic       irq_ack,
  output logic       overrun
);
  vt_state_t  r_state;
  vt_state_t  w_state_nxt;
  logic [7:0] r_line;
  logic       r_pending;
  logic       r_overrun;
  logic       w_load;
  logic       w_latch_en;
  logic       w_busy;
  logic       w_vrst;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_latch_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (line_stb || r_pending) begin
          w_load = 1'b1;
`ifdef VTIMING_ASYNC_PROM_EN
          w_state_nxt = LATCH;
`else
          w_state_nxt = WAIT;
`endif
        end
      end
      WAIT: w_state_nxt = LATCH;
      LATCH: begin
        w_latch_en  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_line    <= RESET_LINE;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)
        r_line <= w_vrst ? RESET_LINE : r_line + 8'd1;
      if (w_busy) begin
        if (line_stb && !r_pending)
          r_pending <= 1'b1;
      end else if (w_load) begin
        // A fresh strobe arriving while the held one is serviced takes the freed slot
        r_pending <= r_pending & line_stb;
      end
      r_overrun <= w_busy & line_stb & r_pending;
    end
  end

  vtiming_decode u_decode (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_latch_en (w_latch_en),
    .i_prom_d   (prom_d),
    .i_irq_ack  (irq_ack),
    .o_vblank   (vblank),
    .o_vsync    (vsync),
    .o_vrst     (w_vrst),
    .o_irq      (irq)
  );

  assign prom_a  = r_line;
  assign vcount  = r_line;
  assign overrun = r_overrun;
endmodule
